alt_pll_pll: RTL and testbench
==============================

# alt_pll_pll

Digital clock-generation block that replaces the vendor PLL primitive in the system clock/reset wrapper. From one input clock it produces two divided, phase-controlled output waveforms `c0` and `c2`, plus a `locked` flag that asserts after a fixed settle period following reset. It sits under the Avalon-controlled PLL wrapper; the wrapper drives `inclk0` from the system clock and consumes `c0` and `c2`.

## Interface

Parameters:
- `C0_DIV`, default 2: `c0` period in `inclk0` cycles; legal values are 2 or greater.
- `C2_DIV`, default 4: `c2` period in `inclk0` cycles; legal values are 2 or greater.
- `C2_PHASE`, default 0: delay of `c2` relative to the lock-aligned grid, in `inclk0` cycles; legal range 0 to `C2_DIV`-1.
- `LOCK_CYCLES`, default 64: number of clock edges after reset release before `locked` asserts; must be 1 or greater.

Ports:
- `inclk0`, input, 1 bit: the only clock; all logic uses its rising edge.
- `reset`, input, 1 bit: one clock; reset is synchronous and active-high.
- `c0`, output, 1 bit: divided clock 0, registered.
- `c2`, output, 1 bit: divided clock 2, registered and phase-shifted.
- `locked`, output, 1 bit: high once the outputs are running.

## Operation

- Internal state:
  - Lock counter, wide enough to hold `LOCK_CYCLES`.
  - `cnt0`, range 0 to `C0_DIV`-1.
  - `cnt2`, range 0 to `C2_DIV`-1.
- Reset (`reset`=1 sampled at an edge) sets:
  - lock counter=0, `locked`=0
  - `cnt0`=0, `c0`=0
  - `cnt2`=(`C2_DIV`−`C2_PHASE`) mod `C2_DIV`, `c2`=0
- Lock phase (`reset`=0, `locked`=0):
  - The lock counter increments on every edge.
  - On the edge where it equals `LOCK_CYCLES`−1, `locked` is set to 1.
  - The counter then stops; it never wraps.
- Run phase (`locked`=1), on every edge:
  - `c0` <= (`cnt0` < `C0_DIV`/2), using integer division. `cnt0` <= 0 if `cnt0`=`C0_DIV`−1, otherwise `cnt0`+1.
  - `c2` <= (`cnt2` < `C2_DIV`/2). `cnt2` wraps at `C2_DIV`−1 the same way.
  - The comparison always uses the pre-update counter value.
- Output waveforms:
  - Even divisor: exactly 50% duty.
  - Odd divisor N: high for (N−1)/2 cycles, low for (N+1)/2 cycles.
- `c0` and `c2` stay low throughout reset and the lock phase; no partial pulses are emitted.
- With `C2_PHASE`=0 and `C2_DIV` a multiple of `C0_DIV`, every `c2` rising edge coincides with a `c0` rising edge.
- Reset mid-operation: the next edge with `reset`=1 returns all state to the reset values and drops `locked`. A full relock of `LOCK_CYCLES` edges follows.
- Illegal parameter values are rejected at elaboration (generate-time error); they are not clamped.

## Timing

- Edge numbering: edge 1 is the first rising edge with `reset`=0.
- `locked` is 1 after edge `LOCK_CYCLES`; with defaults, after edge 64.
- The first run edge is `LOCK_CYCLES`+1. After it:
  - `c0`=1.
  - `c2`=1 only if `C2_PHASE`=0 or `C2_PHASE` > `C2_DIV` − `C2_DIV`/2 (start value already in the high region). Otherwise `c2`=0.
- Output latency: all outputs are registered, with no combinational path from `reset` to outputs.
- Steady state: `c0` has period exactly `C0_DIV` edges and `c2` exactly `C2_DIV` edges, with no drift or jitter.

## Test plan

1. Defaults. Hold `reset` high for 3 edges, then release.
   - Required: `locked`=0 and `c0`=`c2`=0 through edge 63.
   - Required: `locked`=1 after edge 64 and stays high.
2. Defaults, after lock.
   - Required: from edge 65, `c0` sequence is 1,0,1,0,… and `c2` sequence is 1,1,0,0,….
   - Required: each `c2` rise aligns with every second `c0` rise.
3. `C2_PHASE`=1, other parameters default.
   - Required: from edge 65, `c2` sequence is 0,1,1,0,0,1,1,0,…
   - Required: `c0` unchanged from scenario 2.
4. `C0_DIV`=3, `LOCK_CYCLES`=4.
   - Required: `locked` rises after edge 4.
   - Required: `c0` from edge 5 is 1,0,0,1,0,0,…
5. Defaults. Assert `reset` for 1 edge at edge 100.
   - Required: at that edge `locked`, `c0` and `c2` all go to 0.
   - Required: relock after 64 more edges, and the waveforms restart exactly as in scenario 2.
6. Defaults, 1000 run edges.
   - Required: counted `c0` rises = 500 and `c2` rises = 250.
   - Required: no high or low run of `c0` exceeds 1 edge, and none of `c2` exceeds 2 edges.

Source files
------------

// File: rtl/alt_pll_pll_if.sv
// alt_pll_pll_if
//   Bundles the generated clock outputs of alt_pll_pll so the wrapper can
//   pass them around as one port.
//   Signals:
//     c0     - divided clock 0
//     c2     - divided, phase-shifted clock 2
//     locked - high once c0/c2 are running
//   Modports:
//     master - the clock generator (drives all signals)
//     slave  - the consumer (reads all signals)
interface alt_pll_pll_if;
   logic c0;
   logic c2;
   logic locked;

   modport master (output c0, output c2, output locked);
   modport slave  (input  c0, input  c2, input  locked);
endinterface

// File: rtl/alt_pll_pll.sv
// alt_pll_pll
//   Digital stand-in for the vendor PLL. It divides inclk0 into two
//   registered waveforms, c0 and c2, and raises locked after a fixed
//   settle time following reset.
//   Ports:
//     inclk0 - input clock; every register uses its rising edge
//     reset  - synchronous, active-high
//     pll    - alt_pll_pll_if.master carrying c0, c2 and locked
//   Parameters:
//     C0_DIV      - c0 period in inclk0 cycles (>= 2)
//     C2_DIV      - c2 period in inclk0 cycles (>= 2)
//     C2_PHASE    - c2 delay in inclk0 cycles (0 .. C2_DIV-1)
//     LOCK_CYCLES - edges after reset release before locked rises (>= 1)
module alt_pll_pll #(
   parameter int C0_DIV      = 2,
   parameter int C2_DIV      = 4,
   parameter int C2_PHASE    = 0,
   parameter int LOCK_CYCLES = 64
) (
   input  logic          inclk0,
   input  logic          reset,
   alt_pll_pll_if.master pll
);

   // Out-of-range parameters stop elaboration instead of being clamped.
   if (C0_DIV < 2) begin : g_bad_c0_div
      $error("alt_pll_pll: C0_DIV must be 2 or greater");
   end
   if (C2_DIV < 2) begin : g_bad_c2_div
      $error("alt_pll_pll: C2_DIV must be 2 or greater");
   end
   if (C2_PHASE < 0 || C2_PHASE > C2_DIV - 1) begin : g_bad_c2_phase
      $error("alt_pll_pll: C2_PHASE must be in 0 .. C2_DIV-1");
   end
   if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
      $error("alt_pll_pll: LOCK_CYCLES must be 1 or greater");
   end

   localparam int W0 = $clog2(C0_DIV);
   localparam int W2 = $clog2(C2_DIV);
   localparam int LW = $clog2(LOCK_CYCLES + 1);

   localparam logic [W0-1:0] C0_LAST   = W0'(C0_DIV - 1);
   localparam logic [W0-1:0] C0_HALF   = W0'(C0_DIV / 2);
   localparam logic [W2-1:0] C2_LAST   = W2'(C2_DIV - 1);
   localparam logic [W2-1:0] C2_HALF   = W2'(C2_DIV / 2);
   // Starting cnt2 this far "behind" zero delays every c2 edge by C2_PHASE.
   localparam logic [W2-1:0] C2_START  = W2'((C2_DIV - C2_PHASE) % C2_DIV);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

   logic [LW-1:0] lock_cnt_reg;
   logic          locked_reg;
   logic [W0-1:0] cnt0_reg;
   logic [W2-1:0] cnt2_reg;
   logic          c0_reg;
   logic          c2_reg;

   always_ff @(posedge inclk0) begin
      if (reset) begin
         lock_cnt_reg <= '0;
         locked_reg   <= 1'b0;
         cnt0_reg     <= '0;
         cnt2_reg     <= C2_START;
         c0_reg       <= 1'b0;
         c2_reg       <= 1'b0;
      end else if (!locked_reg) begin
         // Settle period: outputs and divider counters are frozen, so no
         // partial pulse can escape before lock.
         lock_cnt_reg <= lock_cnt_reg + LW'(1);
         if (lock_cnt_reg == LOCK_LAST) begin
            locked_reg <= 1'b1;
         end
      end else begin
         // Output compares against the pre-update count; odd divisors
         // therefore spend the extra cycle low.
         c0_reg   <= (cnt0_reg < C0_HALF);
         cnt0_reg <= (cnt0_reg == C0_LAST) ? '0 : cnt0_reg + W0'(1);
         c2_reg   <= (cnt2_reg < C2_HALF);
         cnt2_reg <= (cnt2_reg == C2_LAST) ? '0 : cnt2_reg + W2'(1);
      end
   end

   assign pll.c0     = c0_reg;
   assign pll.c2     = c2_reg;
   assign pll.locked = locked_reg;

endmodule

// File: tb/tb_alt_pll_pll.sv
// tb_alt_pll_pll
//   Directed bench for alt_pll_pll. Three instances share clock and reset:
//     dut_a - all defaults
//     dut_b - C2_PHASE = 1
//     dut_c - C0_DIV = 3, LOCK_CYCLES = 4
//   Expected waveforms are hand-written repeating patterns.
module tb_alt_pll_pll;

   logic clk;
   logic reset;

   alt_pll_pll_if if_a ();
   alt_pll_pll_if if_b ();
   alt_pll_pll_if if_c ();

   alt_pll_pll dut_a (.inclk0(clk), .reset(reset), .pll(if_a));
   alt_pll_pll #(.C2_PHASE(1)) dut_b (.inclk0(clk), .reset(reset), .pll(if_b));
   alt_pll_pll #(.C0_DIV(3), .LOCK_CYCLES(4)) dut_c (.inclk0(clk), .reset(reset), .pll(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Hand-written one-period patterns, starting at the first run edge.
   logic c0a_pat [0:1] = '{1'b1, 1'b0};
   logic c2a_pat [0:3] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic c2b_pat [0:3] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic c0c_pat [0:2] = '{1'b1, 1'b0, 1'b0};

   logic prev_c0a;
   logic prev_c2a;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Compares every output of every instance against the patterns for edge e
   // (edge 1 = first edge after reset release).
   task automatic check_edge(input int e);
      logic exp_v;
      // dut_a
      check($sformatf("lock_a e%0d", e), 32'(if_a.locked), 32'(e >= 64));
      exp_v = (e >= 65) ? c0a_pat[(e - 65) % 2] : 1'b0;
      check($sformatf("c0_a e%0d", e), 32'(if_a.c0), 32'(exp_v));
      exp_v = (e >= 65) ? c2a_pat[(e - 65) % 4] : 1'b0;
      check($sformatf("c2_a e%0d", e), 32'(if_a.c2), 32'(exp_v));
      // dut_b
      check($sformatf("lock_b e%0d", e), 32'(if_b.locked), 32'(e >= 64));
      exp_v = (e >= 65) ? c0a_pat[(e - 65) % 2] : 1'b0;
      check($sformatf("c0_b e%0d", e), 32'(if_b.c0), 32'(exp_v));
      exp_v = (e >= 65) ? c2b_pat[(e - 65) % 4] : 1'b0;
      check($sformatf("c2_b e%0d", e), 32'(if_b.c2), 32'(exp_v));
      // dut_c
      check($sformatf("lock_c e%0d", e), 32'(if_c.locked), 32'(e >= 4));
      exp_v = (e >= 5) ? c0c_pat[(e - 5) % 3] : 1'b0;
      check($sformatf("c0_c e%0d", e), 32'(if_c.c0), 32'(exp_v));
      exp_v = (e >= 5) ? c2a_pat[(e - 5) % 4] : 1'b0;
      check($sformatf("c2_c e%0d", e), 32'(if_c.c2), 32'(exp_v));
      // A c2 rise on dut_a must land on a c0 rise.
      if (!prev_c2a && if_a.c2) begin
         check($sformatf("align_a e%0d", e), 32'({prev_c0a, if_a.c0}), 32'(2'b01));
      end
   endtask

   task automatic check_all_low(input string tag);
      check({tag, " lock_a"}, 32'(if_a.locked), 32'd0);
      check({tag, " c0_a"},   32'(if_a.c0),     32'd0);
      check({tag, " c2_a"},   32'(if_a.c2),     32'd0);
      check({tag, " lock_b"}, 32'(if_b.locked), 32'd0);
      check({tag, " c2_b"},   32'(if_b.c2),     32'd0);
      check({tag, " lock_c"}, 32'(if_c.locked), 32'd0);
      check({tag, " c0_c"},   32'(if_c.c0),     32'd0);
   endtask

   initial begin
      int rises0;
      int rises2;
      int run0;
      int run2;
      int max_run0;
      int max_run2;

      reset    = 1'b1;
      prev_c0a = 1'b0;
      prev_c2a = 1'b0;

      // Reset held for 3 edges.
      repeat (3) step();
      check_all_low("reset");
      reset = 1'b0;

      // Lock phase and early run phase; reset reasserted at edge 100.
      for (int e = 1; e <= 99; e++) begin
         step();
         check_edge(e);
         prev_c0a = if_a.c0;
         prev_c2a = if_a.c2;
      end
      reset = 1'b1;
      step();
      check_all_low("midreset");
      reset    = 1'b0;
      prev_c0a = 1'b0;
      prev_c2a = 1'b0;

      // Relock, then 1000 run edges (65 .. 1064) with rise/run statistics.
      rises0   = 0;
      rises2   = 0;
      run0     = 0;
      run2     = 0;
      max_run0 = 0;
      max_run2 = 0;
      for (int e = 1; e <= 1064; e++) begin
         step();
         check_edge(e);
         if (e >= 65) begin
            if (if_a.c0 && !prev_c0a) rises0++;
            if (if_a.c2 && !prev_c2a) rises2++;
            run0 = (e == 65 || if_a.c0 != prev_c0a) ? 1 : run0 + 1;
            run2 = (e == 65 || if_a.c2 != prev_c2a) ? 1 : run2 + 1;
            if (run0 > max_run0) max_run0 = run0;
            if (run2 > max_run2) max_run2 = run2;
         end
         prev_c0a = if_a.c0;
         prev_c2a = if_a.c2;
      end
      check("c0_rises",   32'(rises0),   32'd500);
      check("c2_rises",   32'(rises2),   32'd250);
      check("c0_max_run", 32'(max_run0), 32'd1);
      check("c2_max_run", 32'(max_run2), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
